program_loader: RTL and testbench



---
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// program_loader: turns a framed byte stream into program-memory word writes.
// Rev 1.0
// ============================================================================
module program_loader #(
  parameter int                    MEMORY_DEPTH = 256,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [16:0] MAX_WORDS = 17'(MEMORY_DEPTH);
  localparam logic [1:0]  LAST_BYTE = 2'(DATA_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                state;
  logic [7:0]            hdr_hi;
  logic [15:0]           word_cnt;
  logic [15:0]           word_idx;
  logic [1:0]            byte_cnt;
  // Only the leading bytes need storing; the final byte goes straight to wr_data_o.
  logic [DATA_WIDTH-9:0] word_asm;

  logic                  transfer;
  logic [15:0]           hdr_n;
  logic [15:0]           next_idx;
  logic [DATA_WIDTH-1:0] word_offset;

  assign transfer    = byte_valid_i & byte_ready_o;
  assign hdr_n       = {hdr_hi, byte_i};
  assign next_idx    = word_idx + 16'd1;
  assign word_offset = DATA_WIDTH'({word_idx, 2'b00});

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_ready_o <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_address_o <= '0;
      wr_data_o    <= '0;
      cpu_hold_o   <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      hdr_hi       <= '0;
      word_cnt     <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      word_asm     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state        <= S_HDR_HI;
            byte_ready_o <= 1'b1;
            cpu_hold_o   <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            byte_cnt     <= '0;
            word_idx     <= '0;
          end
        end

        S_HDR_HI: begin
          if (transfer) begin
            hdr_hi <= byte_i;
            state  <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          if (transfer) begin
            word_cnt <= hdr_n;
            if (hdr_n == 16'd0 || {1'b0, hdr_n} > MAX_WORDS) begin
              state        <= S_ERROR;
              byte_ready_o <= 1'b0;
              error_o      <= 1'b1;
            end else begin
              state    <= S_DATA;
              word_idx <= '0;
              byte_cnt <= '0;
            end
          end
        end

        S_DATA: begin
          if (transfer) begin
            word_asm <= {word_asm[DATA_WIDTH-17:0], byte_i};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == LAST_BYTE) begin
              state        <= S_WRITE;
              byte_ready_o <= 1'b0;
              wr_en_o      <= 1'b1;
              wr_data_o    <= {word_asm, byte_i};
              wr_address_o <= BASE_ADDRESS + word_offset;
            end
          end
        end

        S_WRITE: begin
          wr_en_o  <= 1'b0;
          word_idx <= next_idx;
          if (next_idx == word_cnt) begin
            state      <= S_DONE;
            done_o     <= 1'b1;
            cpu_hold_o <= 1'b0;
          end else begin
            state        <= S_DATA;
            byte_ready_o <= 1'b1;
          end
        end

        default: begin
          state        <= S_IDLE;
          byte_ready_o <= 1'b0;
          wr_en_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_program_loader: directed self-checking bench for program_loader.
// Rev 1.0
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_address_o;
  logic [31:0] wr_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        error_o;

  program_loader #(
    .MEMORY_DEPTH(256),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(32'h00400000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_address_o(wr_address_o),
    .wr_data_o   (wr_data_o),
    .cpu_hold_o  (cpu_hold_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Every cycle with the write strobe high is logged, so a stretched pulse shows as an extra entry.
  logic [31:0] log_addr [0:1023];
  logic [31:0] log_data [0:1023];
  int          wr_count = 0;

  always @(negedge clk) begin
    if (wr_en_o && wr_count < 1024) begin
      log_addr[wr_count] = wr_address_o;
      log_data[wr_count] = wr_data_o;
      wr_count = wr_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string t);
    check_eq({t, "_ready"}, 32'(byte_ready_o), 32'd0);
    check_eq({t, "_wr_en"}, 32'(wr_en_o),      32'd0);
    check_eq({t, "_addr"},  wr_address_o,      32'd0);
    check_eq({t, "_data"},  wr_data_o,         32'd0);
    check_eq({t, "_hold"},  32'(cpu_hold_o),   32'd1);
    check_eq({t, "_done"},  32'(done_o),       32'd0);
    check_eq({t, "_error"}, 32'(error_o),      32'd0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_i       = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check_eq("ready_timeout", 32'(byte_ready_o), 32'd1);
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle_gap(input int cycles);
    byte_valid_i = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      byte_i = 8'($urandom);
      @(negedge clk);
    end
  endtask

  int base;

  initial begin
    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(byte_ready_o), 32'd0);

    // Two-word image from the reference stream
    base = wr_count;
    pulse_start();
    check_eq("t1_hdr_ready", 32'(byte_ready_o), 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h20080005);
    check_eq("t1_wr_strobe", 32'(wr_en_o), 32'd1);
    check_eq("t1_ready_in_write", 32'(byte_ready_o), 32'd0);
    send_word(32'h01095020);
    @(negedge clk);
    check_eq("t1_done", 32'(done_o), 32'd1);
    check_eq("t1_hold", 32'(cpu_hold_o), 32'd0);
    check_eq("t1_wr_count", 32'(wr_count - base), 32'd2);
    check_eq("t1_addr0", log_addr[base],     32'h00400000);
    check_eq("t1_data0", log_data[base],     32'h20080005);
    check_eq("t1_addr1", log_addr[base + 1], 32'h00400004);
    check_eq("t1_data1", log_data[base + 1], 32'h01095020);

    // Rejected headers, then recovery
    base = wr_count;
    pulse_start();
    check_eq("t2_done_clr", 32'(done_o), 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    check_eq("t2_err_zero", 32'(error_o), 32'd1);
    check_eq("t2_hold_zero", 32'(cpu_hold_o), 32'd1);
    check_eq("t2_ready_err", 32'(byte_ready_o), 32'd0);
    pulse_start();
    check_eq("t2_err_clr_start", 32'(error_o), 32'd0);
    send_byte(8'h01); send_byte(8'h01);
    check_eq("t2_err_257", 32'(error_o), 32'd1);
    check_eq("t2_hold_257", 32'(cpu_hold_o), 32'd1);
    check_eq("t2_no_writes", 32'(wr_count - base), 32'd0);
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'hDEADBEEF);
    @(negedge clk);
    check_eq("t2_recover_err", 32'(error_o), 32'd0);
    check_eq("t2_recover_done", 32'(done_o), 32'd1);
    check_eq("t2_recover_cnt", 32'(wr_count - base), 32'd1);
    check_eq("t2_recover_addr", log_addr[base], 32'h00400000);
    check_eq("t2_recover_data", log_data[base], 32'hDEADBEEF);

    // Full-depth image, word i = i
    base = wr_count;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_word(32'(i));
    @(negedge clk);
    check_eq("t3_wr_count", 32'(wr_count - base), 32'd256);
    check_eq("t3_addr0",   log_addr[base],       32'h00400000);
    check_eq("t3_addr128", log_addr[base + 128], 32'h00400200);
    check_eq("t3_data128", log_data[base + 128], 32'h00000080);
    check_eq("t3_addr255", log_addr[base + 255], 32'h004003FC);
    check_eq("t3_data255", log_data[base + 255], 32'h000000FF);
    check_eq("t3_done", 32'(done_o), 32'd1);

    // Single word with stalls between bytes
    base = wr_count;
    pulse_start();
    send_byte(8'h00); idle_gap(3);
    send_byte(8'h01); idle_gap(3 + $urandom_range(0, 2));
    send_byte(8'hCA); idle_gap(3);
    check_eq("t4_ready_in_stall", 32'(byte_ready_o), 32'd1);
    send_byte(8'hFE); idle_gap(3 + $urandom_range(0, 2));
    send_byte(8'h12); idle_gap(3);
    check_eq("t4_no_early_write", 32'(wr_count - base), 32'd0);
    send_byte(8'h34);
    check_eq("t4_wr_strobe", 32'(wr_en_o), 32'd1);
    check_eq("t4_ready_in_write", 32'(byte_ready_o), 32'd0);
    @(negedge clk);
    check_eq("t4_wr_count", 32'(wr_count - base), 32'd1);
    check_eq("t4_data", log_data[base], 32'hCAFE1234);
    check_eq("t4_done", 32'(done_o), 32'd1);

    // Reset in the middle of word 1, then a clean reload
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h11223344);
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    @(negedge clk);
    base = wr_count;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'h55667788);
    @(negedge clk);
    check_eq("t5_wr_count", 32'(wr_count - base), 32'd1);
    check_eq("t5_addr", log_addr[base], 32'h00400000);
    check_eq("t5_data", log_data[base], 32'h55667788);
    check_eq("t5_done", 32'(done_o), 32'd1);

    // start_i during DATA is ignored; start_i in DONE reloads
    base = wr_count;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    pulse_start();
    check_eq("t6_start_in_data_ready", 32'(byte_ready_o), 32'd1);
    send_byte(8'h56); send_byte(8'h78);
    send_word(32'h9ABCDEF0);
    @(negedge clk);
    check_eq("t6_wr_count", 32'(wr_count - base), 32'd2);
    check_eq("t6_data0", log_data[base],     32'h12345678);
    check_eq("t6_addr1", log_addr[base + 1], 32'h00400004);
    check_eq("t6_data1", log_data[base + 1], 32'h9ABCDEF0);
    check_eq("t6_done", 32'(done_o), 32'd1);
    pulse_start();
    check_eq("t6_reload_done", 32'(done_o), 32'd0);
    check_eq("t6_reload_hold", 32'(cpu_hold_o), 32'd1);
    check_eq("t6_reload_ready", 32'(byte_ready_o), 32'd1);
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'h0BADF00D);
    @(negedge clk);
    check_eq("t6_reload_data", log_data[wr_count - 1], 32'h0BADF00D);
    check_eq("t6_reload_finish", 32'(done_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
